sad_best_match: RTL and testbench

- Downstream stage of the SAD processing-element array.
- Consumes one saturated SAD value per candidate position as a valid/ready stream.
- Tracks the minimum SAD and its candidate index across a search window.
- Presents the winner on a held result handshake to the controller.

---
 rtl/sad_pkg.sv | 23 ++
 rtl/sad_min_reg.sv | 62 ++++++
 rtl/sad_best_match.sv | 114 +++++++++++
 tb/tb_sad_best_match.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD datapath: default widths, the saturation
// threshold produced by the PE array, the best-match FSM states, and the clamp
// helper used wherever a SAD value must be limited to the threshold.
package sad_pkg;

  localparam int SAD_W_DEF     = 10;
  localparam int IDX_W_DEF     = 12;
  localparam int THRESHOLD_DEF = 500;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Values above thr collapse to thr. A value equal to thr already means
  // "no match", so it needs no change.
  function automatic logic [31:0] sad_clamp(input logic [31:0] sad,
                                            input logic [31:0] thr);
    return (sad > thr) ? thr : sad;
  endfunction

endpackage

// File: rtl/sad_min_reg.sv
// Running-minimum register for one search window.
//   clk, rst        : clock and synchronous active-high reset (clears to 0)
//   clr_i           : open a window (best_sad <= THRESHOLD, best_idx <= 0)
//   upd_i           : a candidate is accepted this cycle
//   sad_i, idx_i    : raw candidate SAD and its arrival index
//   best_sad_o/idx_o: registered minimum and the index of its first occurrence
//   best_sad_nxt_o  : value best_sad takes at the next edge, so the top can
//                     register match_found on the same edge as the final update
module sad_min_reg
  import sad_pkg::*;
#(
  parameter int SAD_W     = SAD_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [SAD_W-1:0] sad_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic [SAD_W-1:0] best_sad_nxt_o
);

  localparam logic [SAD_W-1:0] THR = SAD_W'(THRESHOLD);

  logic [SAD_W-1:0] sad_cl;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  assign sad_cl = SAD_W'(sad_clamp(32'(sad_i), 32'(THRESHOLD)));

  // Strict less-than: an equal later candidate never replaces the earlier one.
  always_comb begin
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (clr_i) begin
      best_sad_d = THR;
      best_idx_d = '0;
    end else if (upd_i && (sad_cl < best_sad_q)) begin
      best_sad_d = sad_cl;
      best_idx_d = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_sad_o     = best_sad_q;
  assign best_idx_o     = best_idx_q;
  assign best_sad_nxt_o = best_sad_d;

endmodule

// File: rtl/sad_best_match.sv
// Best-match selector downstream of the SAD PE array. Scans a window of SAD
// values (valid/ready in), tracks the first minimum and its index, then holds
// the result on a valid/ready output until the controller takes it.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a window (only honoured in IDLE)
//   in_valid/in_ready     : input handshake; in_sad, in_last ride with it
//   out_valid/out_ready   : result handshake
//   best_sad, best_idx    : minimum clamped SAD and its 0-based index
//   match_found, overflow : best_sad < THRESHOLD; window exceeded 2^IDX_W samples
//   busy                  : high while scanning or holding a result
module sad_best_match
  import sad_pkg::*;
#(
  parameter int SAD_W     = SAD_W_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             match_found,
  output logic             overflow,
  output logic             busy
);

  localparam logic [SAD_W-1:0] THR = SAD_W'(THRESHOLD);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             ovf_q, match_q, in_ready_q, out_valid_q, busy_q;
  logic             fire, clr;
  logic [SAD_W-1:0] best_sad_nxt;

  assign fire = in_valid & in_ready_q;
  assign clr  = (state_q == IDLE) & start;

  sad_min_reg #(
    .SAD_W    (SAD_W),
    .IDX_W    (IDX_W),
    .THRESHOLD(THRESHOLD)
  ) u_min (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (clr),
    .upd_i         (fire),
    .sad_i         (in_sad),
    .idx_i         (cnt_q),
    .best_sad_o    (best_sad),
    .best_idx_o    (best_idx),
    .best_sad_nxt_o(best_sad_nxt)
  );

  // Handshake outputs are registered and change only on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      match_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            match_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (fire) begin
            cnt_q <= cnt_q + 1'b1;
            // Counter about to wrap with more samples still to come.
            if ((&cnt_q) && !in_last) ovf_q <= 1'b1;
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              match_q     <= (best_sad_nxt < THR);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign match_found = match_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sad_best_match.sv
module tb_sad_best_match;

  localparam int SAD_W = 10;
  localparam int IDX_W = 2;
  localparam int THR   = 500;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last, out_ready;
  logic [SAD_W-1:0] in_sad;
  logic in_ready, out_valid, match_found, overflow, busy;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;

  sad_best_match #(.SAD_W(SAD_W), .IDX_W(IDX_W), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_sad(in_sad), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .best_sad(best_sad), .best_idx(best_idx), .match_found(match_found),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sad;
    int idx;
    int match;
    int ovf;
    int fire_cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  bit   seen = 1'b0;
  int   win[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: minimum of the clamped window, then the first position holding
  // it. A window with nothing below threshold reports index 0.
  task automatic push_expected(input int fire_cyc);
    exp_t e;
    int m = THR;
    int first = -1;
    int n = win.size();
    foreach (win[i]) if ((win[i] > THR ? THR : win[i]) < m) m = (win[i] > THR ? THR : win[i]);
    foreach (win[i]) if (first < 0 && (win[i] > THR ? THR : win[i]) == m) first = i;
    e.sad      = m;
    e.idx      = (m == THR) ? 0 : (first % (1 << IDX_W));
    e.match    = (m < THR) ? 1 : 0;
    e.ovf      = (n > (1 << IDX_W)) ? 1 : 0;
    e.fire_cyc = fire_cyc;
    q.push_back(e);
    last_exp = e;
  endtask

  // Monitor: compares every cycle a result is presented, pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid actual=1 expected=0");
      end else begin
        if (!seen) begin
          chk("latency_cycle", cyc, q[0].fire_cyc);
          seen = 1'b1;
        end
        chk("best_sad", best_sad, q[0].sad);
        chk("best_idx", best_idx, q[0].idx);
        chk("match_found", match_found, q[0].match);
        chk("overflow", overflow, q[0].ovf);
        chk("in_ready_in_hold", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int sad, input bit last, input int bubbles, output int fire_cyc);
    int  n;
    bit  done, rdy;
    in_valid = 1'b0;
    repeat (bubbles) tick();
    in_valid = 1'b1;
    in_sad   = SAD_W'(sad);
    in_last  = last;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      rdy = in_ready;
      tick();
      n++;
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    fire_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_window(input int max_bub, input int hold, input bit start_in_hold);
    int fc, n;
    bit v, done;
    do_start();
    foreach (win[i])
      send(win[i], (i == win.size() - 1), (max_bub > 0) ? int'($urandom_range(0, max_bub)) : 0, fc);
    push_expected(fc);
    for (int k = 0; k < hold; k++) begin
      start = start_in_hold && (k == 1);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      v = out_valid;
      tick();
      n++;
      if (v) done = 1'b1;
    end
    out_ready = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout actual=0 expected=1");
    end
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_keep_sad", best_sad, last_exp.sad);
    chk("idle_keep_idx", best_idx, last_exp.idx);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_best_sad"}, best_sad, 0);
    chk({tag, "_best_idx"}, best_idx, 0);
    chk({tag, "_match"}, match_found, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, n, pick;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_sad = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    win = {120, 340, 75, 75};
    run_window(0, 0, 1'b0);

    win = {500, 620, 500};
    run_window(0, 1, 1'b0);

    win = {90, 40};
    run_window(3, 5, 1'b1);

    win = {50, 60, 70, 80, 10};
    run_window(0, 2, 1'b0);

    // Reset in the middle of a window.
    do_start();
    send(300, 1'b0, 0, fc);
    send(100, 1'b0, 0, fc);
    rst = 1'b1;
    tick();
    chk_all_zero("mid_scan_rst");
    rst = 1'b0;
    tick();
    win = {200};
    run_window(0, 0, 1'b0);

    win = {0};
    run_window(0, 1, 1'b0);

    for (int w = 0; w < 25; w++) begin
      win.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pick = $urandom_range(0, 7);
        case (pick)
          0: win.push_back(500);
          1: win.push_back(499);
          2: win.push_back(501);
          3: win.push_back(0);
          default: win.push_back($urandom_range(0, 700));
        endcase
      end
      run_window(2, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
